// File: rtl/hs_chk_pkg.sv
// Shared definitions for the half-subtractor response checker:
// FSM state encodings, default settle time and the expected-response function.
package hs_chk_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      CHECK  = 2'd2
   } hs_state_e;

   localparam int unsigned SETTLE_CYCLES_DEF = 4;
   localparam int unsigned SETTLE_W          = 8;

   // Half subtractor a - b: {borrow, difference}
   function automatic logic [1:0] hs_expected(input logic a, input logic b);
      return {~a & b, a ^ b};
   endfunction

endpackage

// File: rtl/hs_golden.sv
// Combinational golden half subtractor used as the reference for each check.
module hs_golden
   import hs_chk_pkg::*;
(
   input  logic a,
   input  logic b,
   output logic br_exp,
   output logic d_exp
);

   always_comb begin
      {br_exp, d_exp} = hs_expected(a, b);
   end

endmodule

// File: rtl/hs_response_checker.sv
// Half-subtractor response checker: waits for stable stimulus, compares the DUT
// response against hs_golden, keeps pass/fail counters and input coverage.
// Optional failure capture (fail_vec/fail_valid) is enabled by HS_CHK_CAPTURE_EN.
module hs_response_checker
   import hs_chk_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
   parameter int unsigned CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             a,
   input  logic             b,
   input  logic             br,
   input  logic             d,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic             err,
   output logic [3:0]       cov,
   output logic             done,
   output logic             chk_pulse
`ifdef HS_CHK_CAPTURE_EN
   ,
   output logic [3:0]       fail_vec,
   output logic             fail_valid
`endif
);

   localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

   logic                a_q, b_q, br_q, d_q;
   logic [1:0]          ab_prev_q;
   logic                first_q;
   hs_state_e           state_q;
   logic [SETTLE_W-1:0] cnt_q;
   logic [CNT_W-1:0]    pass_q, pass_d;
   logic [CNT_W-1:0]    fail_q, fail_d;
   logic                err_q, err_d;
   logic [3:0]          cov_q, cov_d;
   logic                done_q;
   logic                br_exp, d_exp;
   logic                change, chk, match;

   hs_golden u_golden (
      .a      (a_q),
      .b      (b_q),
      .br_exp (br_exp),
      .d_exp  (d_exp)
   );

   // first_q marks the first enabled cycle after reset or after a disable window
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q       <= 1'b0;
         b_q       <= 1'b0;
         br_q      <= 1'b0;
         d_q       <= 1'b0;
         ab_prev_q <= '0;
         first_q   <= 1'b1;
      end else begin
         a_q       <= a;
         b_q       <= b;
         br_q      <= br;
         d_q       <= d;
         ab_prev_q <= {a_q, b_q};
         first_q   <= ~enable;
      end
   end

   always_comb begin
      change = enable & (first_q | ({a_q, b_q} != ab_prev_q));
      chk    = enable & (state_q == CHECK) & ~change;
      match  = (br_q == br_exp) & (d_q == d_exp);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else if (!enable) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else if (change) begin
         state_q <= SETTLE;
         cnt_q   <= SETTLE_LOAD;
      end else begin
         case (state_q)
            SETTLE: begin
               if (cnt_q == '0) begin
                  state_q <= CHECK;
               end else begin
                  cnt_q <= cnt_q - SETTLE_W'(1);
               end
            end
            CHECK:   state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      pass_d = pass_q;
      fail_d = fail_q;
      err_d  = err_q;
      cov_d  = cov_q;
      if (chk) begin
         if (match) begin
            if (pass_q != '1) pass_d = pass_q + CNT_W'(1);
         end else begin
            if (fail_q != '1) fail_d = fail_q + CNT_W'(1);
            err_d = 1'b1;
         end
         cov_d[{a_q, b_q}] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pass_q <= '0;
         fail_q <= '0;
         err_q  <= 1'b0;
         cov_q  <= '0;
         done_q <= 1'b0;
      end else begin
         pass_q <= pass_d;
         fail_q <= fail_d;
         err_q  <= err_d;
         cov_q  <= cov_d;
         done_q <= &cov_d;
      end
   end

   assign pass_cnt  = pass_q;
   assign fail_cnt  = fail_q;
   assign err       = err_q;
   assign cov       = cov_q;
   assign done      = done_q;
   assign chk_pulse = chk;

`ifdef HS_CHK_CAPTURE_EN
   logic [3:0] fail_vec_q;
   logic       fail_valid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fail_vec_q   <= '0;
         fail_valid_q <= 1'b0;
      end else if (chk && !match && !fail_valid_q) begin
         fail_vec_q   <= {a_q, b_q, br_q, d_q};
         fail_valid_q <= 1'b1;
      end
   end

   assign fail_vec   = fail_vec_q;
   assign fail_valid = fail_valid_q;
`endif

endmodule

// File: tb/tb_hs_response_checker.sv
// Randomised self-checking bench for hs_response_checker with a cycle-level
// behavioural model; runs a default instance and a CNT_W=2 instance in parallel.
module tb_hs_response_checker;

   localparam int S = 4;

   logic       clk = 1'b0;
   logic       rst_n, enable, a, b, br, d;
   logic [7:0] pass_cnt, fail_cnt;
   logic [1:0] s_pass, s_fail;
   logic       err, done, chk_pulse, s_err, s_done, s_chk;
   logic [3:0] cov, s_cov;
   logic       fault_d0, flip_br, flip_d;
`ifdef HS_CHK_CAPTURE_EN
   logic [3:0] fail_vec, s_fail_vec;
   logic       fail_valid, s_fail_valid;
`endif

   always #5 clk = ~clk;

   hs_response_checker #(.SETTLE_CYCLES(S), .CNT_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .a(a), .b(b), .br(br), .d(d),
      .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err(err), .cov(cov),
      .done(done), .chk_pulse(chk_pulse)
`ifdef HS_CHK_CAPTURE_EN
      , .fail_vec(fail_vec), .fail_valid(fail_valid)
`endif
   );

   hs_response_checker #(.SETTLE_CYCLES(S), .CNT_W(2)) u_sat (
      .clk(clk), .rst_n(rst_n), .enable(enable), .a(a), .b(b), .br(br), .d(d),
      .pass_cnt(s_pass), .fail_cnt(s_fail), .err(s_err), .cov(s_cov),
      .done(s_done), .chk_pulse(s_chk)
`ifdef HS_CHK_CAPTURE_EN
      , .fail_vec(s_fail_vec), .fail_valid(s_fail_valid)
`endif
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sat(input int v, input int w);
      int lim;
      lim = (1 << w) - 1;
      return (v > lim) ? lim : v;
   endfunction

   // Behavioural model: a check fires S+1 cycles after the last input change
   // if the inputs stayed stable and enable stayed high throughout.
   logic [1:0] m_ab, m_prev_ab;
   logic       m_br, m_d, m_first, en_seen, m_err, m_cap_valid;
   logic [3:0] m_cov, m_cap_vec;
   bit         pending, chk_this, chk_ok, m_change;
   int         since, n_pass, n_fail, pulses, diff;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ab = '0; m_prev_ab = '0; m_br = 0; m_d = 0;
         m_first = 1; en_seen = 0; pending = 0; chk_this = 0; since = 0;
         n_pass = 0; n_fail = 0; m_err = 0; m_cov = '0;
         m_cap_valid = 0; m_cap_vec = '0;
      end else begin
         if (chk_this) begin
            if (chk_ok) n_pass++;
            else begin
               n_fail++;
               m_err = 1;
               if (!m_cap_valid) begin
                  m_cap_valid = 1;
                  m_cap_vec = {m_ab, m_br, m_d};
               end
            end
            m_cov[m_ab] = 1'b1;
            chk_this = 0;
         end
         m_first   = !en_seen;
         m_prev_ab = m_ab;
         m_ab      = {a, b};
         m_br      = br;
         m_d       = d;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         m_change = enable && (m_first || (m_ab != m_prev_ab));
         en_seen = enable;
         if (!enable) pending = 0;
         else if (m_change) begin
            pending = 1;
            since = 0;
         end else if (pending) begin
            since++;
            if (since == S + 1) begin
               chk_this = 1;
               pending = 0;
            end
         end
         diff = int'(m_ab[1]) - int'(m_ab[0]);
         chk_ok = (m_br == (diff < 0)) && (m_d == (diff != 0));
      end
      if (chk_pulse === 1'b1) pulses++;
      check("chk_pulse", chk_pulse, chk_this);
      check("pass_cnt", pass_cnt, sat(n_pass, 8));
      check("fail_cnt", fail_cnt, sat(n_fail, 8));
      check("err", err, m_err);
      check("cov", cov, m_cov);
      check("done", done, &m_cov);
      check("sat_chk_pulse", s_chk, chk_this);
      check("sat_pass_cnt", s_pass, sat(n_pass, 2));
      check("sat_fail_cnt", s_fail, sat(n_fail, 2));
      check("sat_err", s_err, m_err);
      check("sat_cov", s_cov, m_cov);
      check("sat_done", s_done, &m_cov);
`ifdef HS_CHK_CAPTURE_EN
      check("fail_valid", fail_valid, m_cap_valid);
      check("fail_vec", fail_vec, m_cap_vec);
      check("sat_fail_vec", s_fail_vec, m_cap_vec);
`endif
   end

   // Responder emulating the half subtractor under test, with fault hooks
   task automatic apply(input logic ai, input logic bi);
      a  = ai;
      b  = bi;
      br = (ai < bi) ^ flip_br;
      d  = fault_d0 ? 1'b0 : ((ai != bi) ^ flip_d);
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic reset_pulse();
      rst_n = 0;
      cyc(2);
      rst_n = 1;
   endtask

   task automatic wait_pulse(output int k);
      k = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (chk_pulse === 1'b1) begin
            k = i;
            break;
         end
      end
      @(posedge clk);
      #2;
   endtask

   initial begin
      int k, p0;
      rst_n = 0; enable = 0; fault_d0 = 0; flip_br = 0; flip_d = 0;
      apply(0, 0);
      cyc(3);
      check("reset_pass", pass_cnt, 0);
      check("reset_cov", cov, 0);
      check("reset_done", done, 0);
      check("reset_chk", chk_pulse, 0);

      // All four combinations, held long enough to be checked
      rst_n = 1; enable = 1;
      for (int i = 0; i < 4; i++) begin
         apply(i[1], i[0]);
         cyc(20);
      end
      check("all4_pass", pass_cnt, 4);
      check("all4_fail", fail_cnt, 0);
      check("all4_err", err, 0);
      check("all4_cov", cov, 4'b1111);
      check("all4_done", done, 1);
      apply(0, 0); cyc(20);
      apply(1, 1); cyc(20);
      check("six_pass", pass_cnt, 6);
      check("six_sat_pass", s_pass, 3);

      // d stuck-at-0 with {a,b}=10: sampled one edge after drive, pulse S+1 later
      reset_pulse();
      fault_d0 = 1;
      apply(1, 0);
      wait_pulse(k);
      check("stuck_latency", k, S + 2);
      cyc(8);
      check("stuck_fail", fail_cnt, 1);
      check("stuck_err", err, 1);
`ifdef HS_CHK_CAPTURE_EN
      check("stuck_vec", fail_vec, 4'b1000);
      check("stuck_valid", fail_valid, 1);
`endif
      fault_d0 = 0;

      // Toggling faster than the settle time never produces a check
      reset_pulse();
      p0 = pulses;
      for (int i = 0; i < 15; i++) begin
         apply(i[0], !i[0]);
         cyc(3);
      end
      check("toggle_pulses", pulses - p0, 0);
      check("toggle_pass", pass_cnt, 0);
      check("toggle_fail", fail_cnt, 0);

      // Reset during SETTLE discards the pending check
      reset_pulse();
      apply(1, 0);
      cyc(3);
      rst_n = 0;
      cyc(2);
      check("midrst_pass", pass_cnt, 0);
      check("midrst_fail", fail_cnt, 0);
      rst_n = 1;
      p0 = pulses;
      apply(0, 1);
      cyc(20);
      check("midrst_one_pulse", pulses - p0, 1);
      check("midrst_pass1", pass_cnt, 1);
      check("midrst_cov", cov, 4'b0010);

      // Disabled window: no checks, counters hold; re-enable restarts settling
      enable = 0;
      p0 = pulses;
      for (int i = 0; i < 10; i++) begin
         apply(1'($urandom), 1'($urandom));
         cyc(1);
      end
      apply(1, 1);
      cyc(2);
      check("dis_pulses", pulses - p0, 0);
      check("dis_pass", pass_cnt, 1);
      enable = 1;
      wait_pulse(k);
      check("reen_latency", k, S + 1);
      cyc(2);
      check("reen_pass", pass_cnt, 2);

      // Randomised traffic
      reset_pulse();
      for (int i = 0; i < 150; i++) begin
         enable  = ($urandom_range(0, 9) != 0);
         flip_br = ($urandom_range(0, 9) == 0);
         flip_d  = ($urandom_range(0, 9) == 0);
         apply(1'($urandom), 1'($urandom));
         if ($urandom_range(0, 39) == 0) begin
            rst_n = 0;
            cyc(1);
            rst_n = 1;
         end
         cyc($urandom_range(1, 9));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #400000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
